// File: rtl/pulse_source_if.sv
// Pulse source bundle: run-time controls and button in, raw gate pulses out.
// master: the pulse_source side (consumes button/run/half_period, drives apulse/mpulse).
// slave : the board/controller side (drives controls, observes the two pulses).
interface pulse_source_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 button;       // raw bouncing push button, high = pressed
    logic                 run;          // astable enable
    logic [DIV_WIDTH-1:0] half_period;  // apulse half-period in clk cycles, 0 acts as 1
    logic                 apulse;       // registered astable square wave
    logic                 mpulse;       // registered manual single-step pulse

    modport master (
        input  button,
        input  run,
        input  half_period,
        output apulse,
        output mpulse
    );

    modport slave (
        output button,
        output run,
        output half_period,
        input  apulse,
        input  mpulse
    );
endinterface

// File: rtl/pulse_source.sv
// Raw pulse source for the clock gate: programmable astable divider plus a
// synchronised, debounced, one-shot-per-press manual pulse.
// Ports: clk (rising edge), rst (synchronous, active-high), ps_if (master side:
// button/run/half_period in, apulse/mpulse out). All outputs come straight
// from flops; mpulse rises DEBOUNCE_CYCLES+2 edges after the press is first
// sampled and lasts MPULSE_LEN cycles.
module pulse_source #(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MPULSE_LEN      = 4
) (
    input  logic            clk,
    input  logic            rst,
    pulse_source_if.master  ps_if
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PL_W = (MPULSE_LEN > 1) ? $clog2(MPULSE_LEN) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PL_W-1:0] PL_LAST = PL_W'(MPULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_REL
    } state_t;

    // ------------------------------------------------------------------
    // Astable divider
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] hp_m1;
    logic                 apulse_q, apulse_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        apulse_d  = apulse_q;
        // half_period of 0 behaves like 1, so the terminal count is 0 either way
        hp_m1 = (ps_if.half_period == '0) ? '0
                                          : ps_if.half_period - DIV_WIDTH'(1);
        if (ps_if.run) begin
            // >= rather than == so a half_period lowered below the current
            // count terminates on the next edge instead of wrapping
            if (div_cnt_q >= hp_m1) begin
                div_cnt_d = '0;
                apulse_d  = ~apulse_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == db_q) begin
            // any return to the accepted level restarts the stability count
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // One-shot FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PL_W-1:0] pcnt_q, pcnt_d;
    logic            mpulse_q, mpulse_d;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        mpulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (db_q) begin
                    state_d  = ST_PULSE;
                    pcnt_d   = '0;
                    mpulse_d = 1'b1;
                end
            end
            ST_PULSE: begin
                // pcnt counts completed high cycles beyond the first
                if (pcnt_q == PL_LAST) begin
                    state_d = ST_WAIT_REL;
                end else begin
                    pcnt_d   = pcnt_q + PL_W'(1);
                    mpulse_d = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                // a held button parks here; only a debounced release re-arms
                if (!db_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            apulse_q  <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            mpulse_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            apulse_q  <= apulse_d;
            sync1_q   <= ps_if.button;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            mpulse_q  <= mpulse_d;
        end
    end

    assign ps_if.apulse = apulse_q;
    assign ps_if.mpulse = mpulse_q;

endmodule

// File: tb/tb_pulse_source.sv
// Testbench for pulse_source: divider vector table, directed press/reset/run
// sequences, and a randomized run compared every cycle against a reference
// model built from the behavioural rules (sliding window debounce, timed pulse).
module tb_pulse_source;

    localparam int DW  = 16;
    localparam int DBC = 8;
    localparam int PL  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_source_if #(.DIV_WIDTH(DW)) ps_if ();

    pulse_source #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (DBC),
        .MPULSE_LEN      (PL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ps_if (ps_if)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model, updated on every rising edge from the applied inputs.
    // apulse: elapsed cycles in the current half period.
    // debounce: the level flips once the last DBC synchronised samples all
    //           disagree with the accepted level.
    // manual pulse: a press starts a PL-cycle pulse, then the model waits for
    //           a debounced release before it will fire again.
    // ------------------------------------------------------------------
    int             m_elapsed = 0;
    logic           m_ap = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_mp = 1'b0;
    logic [DBC-1:0] m_hist = '0;
    int             m_hfill = 0;
    int             m_left = 0;
    logic           m_wait = 1'b0;

    always @(posedge clk) begin : ref_model
        int             hp, el, hf, left;
        logic           ap, db, mp, wt;
        logic [DBC-1:0] h;
        if (rst) begin
            m_elapsed <= 0;
            m_ap      <= 1'b0;
            m_s1      <= 1'b0;
            m_s2      <= 1'b0;
            m_db      <= 1'b0;
            m_hist    <= '0;
            m_hfill   <= 0;
            m_left    <= 0;
            m_wait    <= 1'b0;
            m_mp      <= 1'b0;
        end else begin
            hp = (ps_if.half_period == 0) ? 1 : int'(ps_if.half_period);
            el = m_elapsed;
            ap = m_ap;
            if (ps_if.run) begin
                if (el + 1 >= hp) begin
                    el = 0;
                    ap = ~ap;
                end else begin
                    el = el + 1;
                end
            end

            h  = {m_hist[DBC-2:0], m_s2};
            hf = (m_hfill < DBC) ? m_hfill + 1 : DBC;
            db = m_db;
            if (hf == DBC && h == {DBC{~m_db}}) db = ~m_db;

            left = m_left;
            wt   = m_wait;
            mp   = 1'b0;
            if (left > 0) begin
                left = left - 1;
                mp   = (left > 0);
                if (left == 0) wt = 1'b1;
            end else if (wt) begin
                if (!m_db) wt = 1'b0;
            end else if (m_db) begin
                left = PL;
                mp   = 1'b1;
            end

            m_elapsed <= el;
            m_ap      <= ap;
            m_hist    <= h;
            m_hfill   <= hf;
            m_db      <= db;
            m_left    <= left;
            m_wait    <= wt;
            m_mp      <= mp;
            m_s1      <= ps_if.button;
            m_s2      <= m_s1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_apulse", int'(ps_if.apulse), int'(m_ap));
            chk("model_mpulse", int'(ps_if.mpulse), int'(m_mp));
        end
    end

    // ------------------------------------------------------------------
    // Divider vector table: after reset with run=1, count toggles over N edges
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] hp;
        int            cycles;
        int            exp_toggles;
        logic          exp_ap;
    } div_vec_t;

    div_vec_t vecs[5];

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // hold the button and record when mpulse is high over n edges
    task automatic capture(input int n, output int first, output int nhigh);
        ps_if.button = 1'b1;
        first = -1;
        nhigh = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ps_if.mpulse) begin
                if (first < 0) first = i;
                nhigh++;
            end
        end
    endtask

    initial begin
        int   toggles, first, nhigh, highs, seg_left;
        logic prev, frozen_ok;

        vecs[0] = '{hp: 16'd3, cycles: 12, exp_toggles: 4, exp_ap: 1'b0};
        vecs[1] = '{hp: 16'd0, cycles: 5,  exp_toggles: 5, exp_ap: 1'b1};
        vecs[2] = '{hp: 16'd1, cycles: 4,  exp_toggles: 4, exp_ap: 1'b0};
        vecs[3] = '{hp: 16'd5, cycles: 9,  exp_toggles: 1, exp_ap: 1'b1};
        vecs[4] = '{hp: 16'd2, cycles: 7,  exp_toggles: 3, exp_ap: 1'b1};

        rst               = 1'b1;
        ps_if.button      = 1'b0;
        ps_if.run         = 1'b1;
        ps_if.half_period = 16'd3;
        tick();
        tick();
        chk("reset_apulse", int'(ps_if.apulse), 0);
        chk("reset_mpulse", int'(ps_if.mpulse), 0);
        chk_en = 1'b1;

        // first rising edge of apulse at the 3rd edge after reset release
        rst = 1'b0;
        tick();
        tick();
        chk("hp3_edge2_low", int'(ps_if.apulse), 0);
        tick();
        chk("hp3_edge3_high", int'(ps_if.apulse), 1);

        foreach (vecs[v]) begin
            ps_if.half_period = vecs[v].hp;
            ps_if.run         = 1'b1;
            do_reset();
            prev    = ps_if.apulse;
            toggles = 0;
            for (int i = 0; i < vecs[v].cycles; i++) begin
                tick();
                if (ps_if.apulse != prev) toggles++;
                prev = ps_if.apulse;
            end
            chk($sformatf("vec%0d_toggles", v), toggles, vecs[v].exp_toggles);
            chk($sformatf("vec%0d_apulse", v), int'(ps_if.apulse), int'(vecs[v].exp_ap));
        end

        // run hold mid half-period: count 4 of 10, freeze, then resume
        ps_if.half_period = 16'd10;
        do_reset();
        repeat (4) tick();
        ps_if.run = 1'b0;
        frozen_ok = 1'b1;
        repeat (10) begin
            tick();
            if (ps_if.apulse !== 1'b0) frozen_ok = 1'b0;
        end
        chk("run_hold_frozen", int'(frozen_ok), 1);
        ps_if.run = 1'b1;
        repeat (5) tick();
        chk("run_resume_before", int'(ps_if.apulse), 0);
        tick();
        chk("run_resume_toggle", int'(ps_if.apulse), 1);

        // lowering half_period 100 -> 2 at count 50
        ps_if.half_period = 16'd100;
        do_reset();
        repeat (50) tick();
        ps_if.half_period = 16'd2;
        tick();
        chk("lower_hp_next_edge", int'(ps_if.apulse), 1);
        tick();
        chk("lower_hp_hold1", int'(ps_if.apulse), 1);
        tick();
        chk("lower_hp_toggle2", int'(ps_if.apulse), 0);
        tick();
        tick();
        chk("lower_hp_toggle3", int'(ps_if.apulse), 1);

        // debounce rejection: 5-cycle high/low phases for 60 cycles
        ps_if.half_period = 16'd3;
        do_reset();
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            ps_if.button = ((i / 5) % 2 == 0);
            tick();
            if (ps_if.mpulse) highs++;
        end
        ps_if.button = 1'b0;
        repeat (20) tick();
        chk("bounce_rejected", highs, 0);

        // clean press, held 50 cycles: pulse on edges k+10..k+13 only
        capture(50, first, nhigh);
        chk("press1_first", first, 10);
        chk("press1_len", nhigh, PL);
        ps_if.button = 1'b0;
        repeat (20) tick();
        capture(30, first, nhigh);
        chk("press2_first", first, 10);
        chk("press2_len", nhigh, PL);
        ps_if.button = 1'b0;
        repeat (20) tick();

        // reset during the 2nd mpulse cycle with the button still held
        capture(12, first, nhigh);
        chk("midpulse_first", first, 10);
        chk("midpulse_high", int'(ps_if.mpulse), 1);
        rst = 1'b1;
        tick();
        chk("midpulse_rst_mpulse", int'(ps_if.mpulse), 0);
        chk("midpulse_rst_apulse", int'(ps_if.apulse), 0);
        rst = 1'b0;
        capture(30, first, nhigh);
        chk("after_rst_first", first, 10);
        chk("after_rst_len", nhigh, PL);
        ps_if.button = 1'b0;
        repeat (20) tick();

        // randomized: bursts of bounces, long holds, run/half_period changes,
        // occasional resets; compared each cycle against the model
        seg_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                ps_if.button = ~ps_if.button;
                seg_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7))
                                                       : int'($urandom_range(9, 40));
            end
            seg_left--;
            if ($urandom_range(0, 49) == 0) ps_if.half_period = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) ps_if.run = ~ps_if.run;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
